// File: rtl/dragon_mover.sv
// dragon_mover: steps a dragon one grid cell per move period toward a target, frozen while stunned.
// Define DRAGON_BODY_EN to add a 4-entry body history on body_pos.
module dragon_mover #(
  parameter int          MOVE_PERIOD = 2,
  parameter int          STUN_TICKS  = 8,
  parameter logic [7:0]  START_POS   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       dragon_hurt,
  input  logic [7:0] target_pos,
  output logic [7:0] dragon_pos,
  output logic [1:0] dragon_dir,
  output logic       target_reached,
  output logic       dragon_stunned
`ifdef DRAGON_BODY_EN
  ,
  output logic [31:0] body_pos
`endif
);
  typedef enum logic {MOVE, STUN} state_t;
  localparam logic [3:0] PMAX    = 4'(MOVE_PERIOD - 1);
  localparam logic [3:0] STUN_LD = 4'(STUN_TICKS);
  state_t     r_state, w_state;
  logic [3:0] r_pre, w_pre, r_stun, w_stun;
  logic [3:0] w_x, w_y, w_tx, w_ty, w_dx, w_dy;
  logic [7:0] w_pos;
  logic [1:0] w_dir;
  logic       w_step, w_move, w_reached;
  assign dragon_stunned = r_state == STUN;
  always_comb begin
    w_x       = dragon_pos[7:4];
    w_y       = dragon_pos[3:0];
    w_tx      = target_pos[7:4];
    w_ty      = target_pos[3:0];
    w_dx      = w_x > w_tx ? w_x - w_tx : w_tx - w_x;
    w_dy      = w_y > w_ty ? w_y - w_ty : w_ty - w_y;
    w_step    = !dragon_hurt && r_state == MOVE && trigger && r_pre == PMAX;
    w_move    = w_step && dragon_pos != target_pos;
    w_reached = w_step && !w_move && !target_reached;
    w_state   = r_state;
    w_pre     = r_pre;
    w_stun    = r_stun;
    w_pos     = dragon_pos;
    w_dir     = dragon_dir;
    if (dragon_hurt) begin
      w_state = STUN;
      w_stun  = STUN_LD;
      w_pre   = 4'd0;
    end else if (r_state == STUN) begin
      if (r_stun == 4'd0) w_state = MOVE;
      else if (trigger) w_stun = r_stun - 4'd1;
    end else if (trigger) begin
      w_pre = r_pre == PMAX ? 4'd0 : r_pre + 4'd1;
    end
    // Larger axis distance wins; ties go to X. Moving toward the target can never wrap.
    if (w_move && w_dx >= w_dy) begin
      w_dir      = w_tx > w_x ? 2'd1 : 2'd3;
      w_pos[7:4] = w_tx > w_x ? w_x + 4'd1 : w_x - 4'd1;
    end else if (w_move) begin
      w_dir      = w_ty > w_y ? 2'd2 : 2'd0;
      w_pos[3:0] = w_ty > w_y ? w_y + 4'd1 : w_y - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= MOVE;
      r_pre          <= 4'd0;
      r_stun         <= 4'd0;
      dragon_pos     <= START_POS;
      dragon_dir     <= 2'd0;
      target_reached <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_pre          <= w_pre;
      r_stun         <= w_stun;
      dragon_pos     <= w_pos;
      dragon_dir     <= w_dir;
      target_reached <= w_reached;
    end
  end
`ifdef DRAGON_BODY_EN
  logic [31:0] r_body;
  assign body_pos = r_body;
  always_ff @(posedge clk) begin
    if (reset) r_body <= {4{START_POS}};
    else if (w_move) r_body <= {r_body[23:0], dragon_pos};
  end
`endif
endmodule
